// File: rtl/ctrl_pkg.sv
// Shared types and constants for the register-file scoreboard / issue controller.
package ctrl_pkg;

  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  localparam int REG_SP = 13;
  localparam int REG_LR = 14;
  localparam int REG_PC = 15;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/ctrl_hazard_if.sv
// Decode/write-back facing signal bundle of the issue controller.
interface ctrl_hazard_if;
  import ctrl_pkg::*;

  logic              i_issue_valid;
  logic              i_issue_rd_en;
  logic [REG_AW-1:0] i_issue_rd;
  logic              i_issue_rs1_en;
  logic [REG_AW-1:0] i_issue_rs1;
  logic              i_issue_rs2_en;
  logic [REG_AW-1:0] i_issue_rs2;
  logic              i_wb_en;
  logic [REG_AW-1:0] i_wb_addr;
  logic              i_drain_req;
  logic              i_flush;

  logic              o_issue_ready;
  logic              o_stall;
  logic [NREGS-1:0]  o_busy;
  logic              o_drain_done;
  logic              o_err;
  logic [15:0]       o_stall_cycles;

  modport master (
    output i_issue_valid, i_issue_rd_en, i_issue_rd, i_issue_rs1_en, i_issue_rs1,
           i_issue_rs2_en, i_issue_rs2, i_wb_en, i_wb_addr, i_drain_req, i_flush,
    input  o_issue_ready, o_stall, o_busy, o_drain_done, o_err, o_stall_cycles
  );

  modport slave (
    input  i_issue_valid, i_issue_rd_en, i_issue_rd, i_issue_rs1_en, i_issue_rs1,
           i_issue_rs2_en, i_issue_rs2, i_wb_en, i_wb_addr, i_drain_req, i_flush,
    output o_issue_ready, o_stall, o_busy, o_drain_done, o_err, o_stall_cycles
  );

endinterface

// File: rtl/ctrl_sb_cnt.sv
// One register's pending-write counter: saturating up/down with clear and status flags.
module ctrl_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic zero_o,
  output logic max_o,
  output logic one_o,
  output logic nxt_zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);
  assign max_o  = (cnt_q == '1);
  assign one_o  = (cnt_q == CNT_W'(1));

  // Simultaneous inc and dec cancel; dec at zero and inc at max are ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !max_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign nxt_zero_o = (cnt_d == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_hazard.sv
// Register scoreboard and issue controller: RAW/overflow hazards, drain sequence, error and stall stats.
// Optional same-cycle write-back bypass of source operands when CTRL_HAZARD_WB_BYPASS_EN is defined.
module ctrl_hazard
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  ctrl_hazard_if.slave  hz
);

`ifdef CTRL_HAZARD_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  logic [NREGS-1:0] zero_v, max_v, one_v, nxt_zero_v;
  logic [NREGS-1:0] inc_v, dec_v;

  state_e      state_q, state_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic wb_act;
  logic pend_rs1, pend_rs2;
  logic hazard, ready, stall, accept, all_zero_nxt;

  for (genvar n = 0; n < NREGS; n++) begin : g_cnt
    ctrl_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (inc_v[n]),
      .dec_i      (dec_v[n]),
      .clr_i      (hz.i_flush),
      .zero_o     (zero_v[n]),
      .max_o      (max_v[n]),
      .one_o      (one_v[n]),
      .nxt_zero_o (nxt_zero_v[n])
    );
  end

  // A source whose last outstanding write retires this very cycle is free only with bypass.
  assign pend_rs1 = !zero_v[hz.i_issue_rs1] &&
                    !(WB_BYPASS && one_v[hz.i_issue_rs1] && hz.i_wb_en &&
                      (hz.i_wb_addr == hz.i_issue_rs1));
  assign pend_rs2 = !zero_v[hz.i_issue_rs2] &&
                    !(WB_BYPASS && one_v[hz.i_issue_rs2] && hz.i_wb_en &&
                      (hz.i_wb_addr == hz.i_issue_rs2));

  assign hazard = hz.i_issue_valid &&
                  ((hz.i_issue_rs1_en && pend_rs1) ||
                   (hz.i_issue_rs2_en && pend_rs2) ||
                   (hz.i_issue_rd_en  && max_v[hz.i_issue_rd]));

  assign accept       = hz.i_issue_valid && ready && !hz.i_flush;
  assign wb_act       = hz.i_wb_en && !hz.i_flush;
  assign stall        = hz.i_issue_valid && !ready;
  assign all_zero_nxt = &nxt_zero_v;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int n = 0; n < NREGS; n++) begin
      inc_v[n] = accept && hz.i_issue_rd_en && (hz.i_issue_rd == REG_AW'(n));
      dec_v[n] = wb_act && (hz.i_wb_addr == REG_AW'(n));
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      RUN, STALL: begin
        ready = !hazard;
        if (hz.i_drain_req) begin
          // Nothing left in flight after this cycle: complete without parking in DRAIN.
          if (all_zero_nxt) begin
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = DRAIN;
          end
        end else if (hazard) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        ready = 1'b0;
        if (all_zero_nxt) begin
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (hz.i_flush) begin
      state_d = RUN;
      done_d  = 1'b0;
    end
  end

  assign busy_d      = ~nxt_zero_v;
  assign err_d       = err_q || (wb_act && zero_v[hz.i_wb_addr]);
  assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      busy_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.o_issue_ready  = ready;
  assign hz.o_stall        = stall;
  assign hz.o_busy         = busy_q;
  assign hz.o_drain_done   = done_q;
  assign hz.o_err          = err_q;
  assign hz.o_stall_cycles = stall_cnt_q;

endmodule

// File: doc/ctrl_hazard.md
# ctrl_hazard

Register-file scoreboard and issue controller for the pipelined Thumb core. It tracks outstanding destination-register writes between decode/issue and write-back, and holds issue while an instruction reads a register that an older instruction has not yet written. It also supports a drain sequence that blocks issue until every in-flight write has retired. It sits between the decode stage, which presents operands, and the write-back register-enable decode, which retires writes.

## Interface
- NREGS, 16: architectural registers tracked (r0–r12, SP=13, LR=14, PC=15)
- CNT_W, 2: per-register pending-counter width; max in-flight writes per register = 2^CNT_W−1
- clk  input  1  single core clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-low
- i_issue_valid  input  1  decode presents an instruction
- i_issue_rd_en / i_issue_rd  input  1 / 4  instruction writes register rd
- i_issue_rs1_en / i_issue_rs1  input  1 / 4  source operand 1
- i_issue_rs2_en / i_issue_rs2  input  1 / 4  source operand 2
- i_wb_en / i_wb_addr  input  1 / 4  write-back retires a write to wb_addr
- i_drain_req  input  1  request a pipeline drain (single-cycle pulse)
- i_flush  input  1  clear all scoreboard state
- o_issue_ready  output  1  issue accepted this cycle when valid
- o_stall  output  1  valid issue blocked this cycle
- o_busy  output  NREGS  bit n set when register n has a pending write
- o_drain_done  output  1  one-cycle pulse when a drain completes
- o_err  output  1  sticky: write-back to a register with a zero counter
- o_stall_cycles  output  16  saturating count of stalled cycles

## Operation
- Per-register counter cnt[n]. pending(n) = cnt[n] != 0.
- Hazard, when i_issue_valid is high, is any of:
  - rs1_en and pending(rs1)
  - rs2_en and pending(rs2)
  - rd_en and cnt[rd] at maximum
- FSM states, encoded in ctrl_pkg:
  - RUN: o_issue_ready = !hazard. Hazard with valid → STALL. i_drain_req → DRAIN.
  - STALL: o_issue_ready = !hazard. Hazard cleared → RUN (accept happens that cycle). i_drain_req → DRAIN.
  - DRAIN: o_issue_ready = 0. When all cnt are zero, pulse o_drain_done and go to RUN. If all counters are already zero on entry, the pulse occurs one cycle after the request.
- o_stall = i_issue_valid & !o_issue_ready (covers both STALL and DRAIN).
- Accept = i_issue_valid & o_issue_ready. Accept with rd_en increments cnt[rd].
- i_wb_en decrements cnt[wb_addr].
- Accept and write-back to the same register in the same cycle: counter unchanged.
- Write-back to a register whose counter is zero: counter stays 0 and o_err is set.
- i_flush has highest priority. It clears all counters, forces RUN, and ignores issue, write-back and drain that cycle. o_err and o_stall_cycles are not cleared by flush.
- o_stall_cycles increments on every cycle with o_stall high and saturates at 0xFFFF.

## Timing
- Reset values:
  - FSM = RUN
  - all cnt = 0, o_busy = 0
  - o_drain_done = 0, o_err = 0, o_stall_cycles = 0
  - o_issue_ready = 1 (combinational, follows counters)
  - o_stall = 0
- Reset asserted mid-operation discards all pending state immediately.
- o_issue_ready and o_stall are combinational from registered state and the current-cycle inputs.
- o_busy, o_drain_done, o_err and o_stall_cycles are registered.
- A counter update is visible one cycle after accept or write-back; there is no same-cycle self-dependency.
- Back-to-back dependent issue (I1 writes r3, I2 reads r3) stalls I2 until the cycle after I1's write-back, or the same cycle when bypass is enabled.

## Configuration
- CTRL_HAZARD_WB_BYPASS_EN defined:
  - a source register with cnt == 1 and a matching i_wb_en/i_wb_addr in the same cycle is treated as not pending.
  - the issue is accepted in the write-back cycle.
- Not defined:
  - the source stays pending that cycle.
  - o_issue_ready rises the following cycle.

## Structure
- ctrl_pkg holds:
  - state enum {RUN, STALL, DRAIN}
  - NREGS
  - REG_SP=13, REG_LR=14, REG_PC=15
- Sub-module ctrl_sb_cnt: one CNT_W-bit up/down counter with inc, dec, clr, zero and max flags, instantiated NREGS times.
- ctrl_hazard holds the FSM, hazard compare, error flag and stall counter.

## Test plan
- Issue ADD writing r2 (rd_en, rd=2), then issue with rs1=2 while no write-back → o_stall=1 and o_busy[2]=1. Write-back r2 → ready next cycle; with bypass, ready in the same cycle.
- Three issues writing SP (rd=13) with CNT_W=2, no write-back → the fourth stalls. One write-back of 13 → the fourth is accepted and cnt[13] returns to 3.
- Accept with rd=5 and write-back of r5 in the same cycle while cnt[5]=1 → cnt[5] stays 1 and o_busy[5]=1.
- Write-back r7 with cnt[7]=0 → o_err=1 and stays set; o_busy[7]=0.
- Pending r1 and r4, pulse i_drain_req → ready=0. Write-backs of r1 then r4 → o_drain_done pulses one cycle after the second. Then issue with rs1=1 → accepted.
- Stall for 10 cycles, then i_flush → o_busy=0, o_stall_cycles=10, FSM=RUN.
